// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame width and baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    localparam int DATA_BITS = 8;

    function automatic int calc_tick_div(
        input int clk_freq,
        input int baud,
        input int oversample
    );
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider emitting a one-cycle tick every DIV clocks.
// A synchronous clear holds the count at zero so the phase follows the caller.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = !clr && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver with 3-sample majority vote and break handling.
// Optional parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;

    localparam logic [SW-1:0] S_LO  = SW'(M - 1);
    localparam logic [SW-1:0] S_MID = SW'(M);
    localparam logic [SW-1:0] S_HI  = SW'(M + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("uart_rx_oversampled: TICK_DIV must be >= 2");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_rx_oversampled: OVERSAMPLE must be even and >= 8");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_par
        $error("uart_rx_oversampled: PARITY_ODD must be 0 or 1");
    end

    uart_state_t          state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_d;
    logic                 fall;
    logic                 tick;
    logic [SW-1:0]        s_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 v0;
    logic                 v1;
    logic                 vote;
    logic                 vote_tick;
    logic                 end_tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign fall = rx_d && !rx_s;

    uart_baud_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (state == IDLE),
        .tick  (tick)
    );

    // Third sample is the live line value at the vote tick.
    assign vote      = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
    assign vote_tick = tick && (s_cnt == S_HI);
    assign end_tick  = tick && (s_cnt == S_END);

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            s_cnt      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            v0         <= 1'b1;
            v1         <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (tick && (state != IDLE) && (state != BREAK)) begin
                s_cnt <= (s_cnt == S_END) ? '0 : s_cnt + SW'(1);
                if (s_cnt == S_LO) v0 <= rx_s;
                if (s_cnt == S_MID) v1 <= rx_s;
            end

            unique case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                        busy  <= 1'b1;
                        s_cnt <= '0;
                    end
                end
                START: begin
                    if (vote_tick && vote) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (end_tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (vote_tick) begin
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                    end
                    if (end_tick) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (vote_tick) par_bit <= vote;
`endif
                    if (end_tick) state <= STOP;
                end
                STOP: begin
                    // Leave at mid-stop so a zero-idle next start is caught.
                    if (vote_tick) begin
                        if (vote) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bit
                                        != (^shreg ^ 1'(PARITY_ODD));
`endif
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                            s_cnt     <= '0;
                        end
                    end
                end
                BREAK: begin
                    if (tick) begin
                        if (!rx_s) begin
                            s_cnt <= '0;
                        end else if (s_cnt == S_END) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            s_cnt <= '0;
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: frame-level model feeds a queue,
// a monitor pops and checks on every output strobe.
module tb_uart_rx_oversampled;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int PODD       = 0;
    localparam int BIT_CLKS   = CLK_FREQ / BAUD;

    typedef struct {
        bit         frame;
        logic [7:0] data;
        bit         perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    exp_t       sb[$];
    logic [7:0] last_good = 8'h00;
    int         vectors = 0;
    int         miscompares = 0;
    logic       busy_prev = 1'b0;

    uart_rx_oversampled #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE),
        .PARITY_ODD (PODD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic drive_bit(input logic v, input bit spike);
        for (int c = 0; c < BIT_CLKS; c++) begin
            @(negedge clk);
            rx = (spike && c >= 75 && c < 85) ? ~v : v;
        end
    endtask

    // Frame-level model: good stop -> byte delivered, bad stop -> one error.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input bit spikes, input bit bad_par);
        exp_t e;
        logic par_sent;
        par_sent = (^b) ^ PODD[0] ^ bad_par;
        e.frame = !stop_ok;
        e.perr  = 1'b0;
        if (stop_ok) begin
            e.data = b;
`ifdef UART_RX_PARITY_EN
            e.perr = (par_sent != ((^b) ^ PODD[0]));
`endif
            last_good = b;
        end else begin
            e.data = last_good;
        end
        sb.push_back(e);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i], spikes);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_sent, 1'b0);
`endif
        drive_bit(stop_ok, 1'b0);
    endtask

    task automatic hold_break(input int low_clks);
        for (int c = 0; c < low_clks; c++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(400);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (data_valid || frame_err || parity_err)) begin
                chk("valid_and_ferr", 32'(data_valid & frame_err), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("frame_err", 32'(frame_err), 32'(e.frame));
                    chk("data_valid", 32'(data_valid), 32'(!e.frame));
                    chk("data_out", 32'(data_out), 32'(e.data));
                    chk("parity_err", 32'(parity_err), 32'(e.perr));
                    if (data_valid)
                        chk("busy_fall", 32'({busy_prev, busy}), 2);
                end
            end
            busy_prev = busy;
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] b;
        repeat (5) @(negedge clk);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_perr", 32'(parity_err), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        idle(50);

        send_frame(8'h91, 1, 0, 0);
        idle(100);

        send_frame(8'hFF, 1, 0, 0);
        send_frame(8'hF4, 1, 0, 0);
        send_frame(8'h00, 1, 0, 0);
        idle(100);

        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rx = 1'b0;
            if (c == 20) chk("glitch_busy_hi", 32'(busy), 1);
        end
        idle(200);
        chk("glitch_busy_lo", 32'(busy), 0);
        send_frame(8'hA5, 1, 0, 0);
        idle(100);

        send_frame(8'h3C, 0, 0, 0);
        hold_break(3000);
        chk("break_data_kept", 32'(data_out), 32'h A5);
        send_frame(8'h55, 1, 0, 0);
        idle(100);

        send_frame(8'h91, 1, 1, 0);
        idle(100);

        b = 8'h77;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i], 1'b0);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            rx = b[3];
        end
        #2 reset = 1'b1;
        #1;
        chk("arst_data_out", 32'(data_out), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(data_valid), 0);
        repeat (5) @(negedge clk);
        rx = 1'b1;
        last_good = 8'h00;
        reset = 1'b0;
        idle(100);
        send_frame(8'h12, 1, 0, 1);
        idle(100);

        for (int n = 0; n < 14; n++) begin
            bit ok;
            int gap;
            ok  = ($urandom_range(0, 7) != 0);
            gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 300);
            send_frame(8'($urandom_range(0, 255)), ok,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (!ok) hold_break($urandom_range(0, 600));
            else if (gap > 0) idle(gap);
        end

        idle(400);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
Standalone UART receiver for the FPGA UART link: 8N1 serial in, parallel byte out with a one-cycle valid strobe.
- Uses 16x oversampling with 3-sample majority voting, a start-bit glitch filter and framing-error detection.
- Sits opposite the transmit path of the UART controller, on the rx pin or in tx->rx loopback.
- Replaces simple mid-bit single-sample reception.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD, 9600, line baud rate.
OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only with UART_RX_PARITY_EN.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
rx  input  1  asynchronous serial line, idle high.
data_out  output  8  last good received byte; holds until the next good byte.
data_valid  output  1  one-cycle pulse when data_out is updated.
frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without the macro.
busy  output  1  high from start detect until return to IDLE.

Behaviour:
Clock and reset:
- One clock, clk. Reset is asynchronous and active-high on port reset; all flops clear immediately when reset rises.

Reset values:
- data_out = 8'h00; data_valid, frame_err, parity_err, busy = 0.
- Synchroniser flops = 1; state = IDLE.

Input synchroniser:
- rx passes through a 2-flop synchroniser (rx_s). All logic uses rx_s only.
- Latency from a pin edge to rx_s is 2 cycles.

Tick generator:
- TICK_DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated. Elaboration error if TICK_DIV < 2.
- Counter emits a one-cycle tick every TICK_DIV clocks.
- Counter is held at 0 in IDLE and restarts on start detect, so sampling phase aligns to the start edge.

Sample counter:
- s_cnt counts 0..OVERSAMPLE-1 per bit and wraps to 0 on the tick after OVERSAMPLE-1.
- Majority vote uses samples at s_cnt = M-1, M, M+1, where M = OVERSAMPLE/2.
- Bit value = majority of the 3 samples, evaluated at tick M+1.

State machine:
- IDLE:
  - rx_s high->low -> START; busy = 1.
- START:
  - At the vote, majority 1 -> IDLE (glitch rejected: no outputs, busy = 0).
  - Majority 0 -> DATA at the end of the bit.
- DATA:
  - 8 bits, LSB first, shifted into a shift register; bit index 0..7.
  - After bit 7 -> PARITY if the macro is enabled, otherwise STOP.
- STOP, at the vote:
  - Majority 1 -> data_out = shift register, data_valid pulses the next cycle -> IDLE immediately (mid-stop resync; no wait for the bit end).
  - Majority 0 -> frame_err pulses, data_out unchanged -> BREAK.
- BREAK:
  - Wait until rx_s = 1 for one full bit time (OVERSAMPLE ticks), then -> IDLE.
  - A break or stuck-low line therefore produces exactly one frame_err.

Timing and boundary conditions:
- Latency: data_valid rises about 9.5 bit times plus 3 clocks after the start falling edge on the pin.
- A new start edge arriving in the cycle IDLE is entered is detected; back-to-back frames with zero idle are received without loss.
- data_valid and frame_err are never high in the same cycle.
- There is no backpressure. The consumer must capture data_out within one frame time; the next good byte overwrites it.
- Reset asserted mid-frame aborts immediately with no pulse. After release, the line must be seen high before a start is accepted: the synchroniser resets to 1 and a start needs a falling edge.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - PARITY state follows DATA and samples one extra bit by majority vote.
  - Expected parity = XOR of the 8 data bits XOR PARITY_ODD.
  - On mismatch, parity_err pulses in the same cycle data_valid would. data_valid still pulses and data_out still updates if the stop bit is good.
  - A bad stop bit takes precedence: frame_err only, no parity_err.
- Undefined:
  - No PARITY state; parity_err is tied 0; frame is 8N1.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - DATA_BITS = 8;
  - function computing TICK_DIV from CLK_FREQ, BAUD and OVERSAMPLE.
  - Shared with the transmitter.
- One sub-module: uart_baud_tick (counter with sync clear, tick output), reused by the TX side at OVERSAMPLE = 1.

Test Plan:
All scenarios use CLK_FREQ = 1_600_000, BAUD = 10_000, OVERSAMPLE = 16: TICK_DIV = 10, 160 clocks per bit.
1. Send 8'h91 8N1 -> one data_valid pulse, data_out = 8'h91, frame_err = 0, busy falls in the same cycle data_valid rises.
2. Send 8'hFF, 8'hF4, 8'h00 back-to-back with no idle -> three valid pulses, bytes in order, no frame_err.
3. Drive a 40-clock low glitch on an idle line -> no pulses; busy high then low; the following 8'hA5 is received correctly.
4. Send 8'h3C with the stop bit held low, then hold rx low for 3000 clocks, then high -> exactly one frame_err, data_out keeps its previous value, next 8'h55 received.
5. Send 8'h91 with a 1-sample (10-clock) inverted spike at each data-bit centre -> majority vote yields 8'h91.
6. Assert reset mid-DATA of 8'h77 -> all outputs 0 asynchronously; after release, 8'h12 received. With UART_RX_PARITY_EN and even parity, 8'h12 with parity bit 1 -> data_valid plus parity_err.
